// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, default width and duty stepping helpers for the PWM ramp scheduler.
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int unsigned clamp(int unsigned v, int unsigned lim);
    return v > lim ? lim : v;
  endfunction
  // Step 0 means jump straight to target; never overshoots.
  function automatic int unsigned step_toward(int unsigned cur, int unsigned tgt, int unsigned step);
    int unsigned d, s;
    d = tgt > cur ? tgt - cur : cur - tgt;
    s = (step == 0 || step > d) ? d : step;
    return tgt > cur ? cur + s : cur - s;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer that moves past each winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  always_comb begin
    idx = ptr;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) idx = j;
    end
    grant = (|req) ? NUM_REQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance) ptr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler: round-robin shares one PWM generator, ramping its duty one step per PWM period.
// Optional PWM_RAMP_SCHED_ABORT_EN adds an abort input that stops a ramp where it stands.
module pwm_ramp_scheduler import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_duty,
  input  logic [NUM_REQ*WIDTH-1:0] req_step,
  input  logic [WIDTH-1:0]         cfg_period,
  input  logic                     period_start,
  output logic [WIDTH-1:0]         pwm_period,
  output logic [WIDTH-1:0]         pwm_duty_cycle,
  output logic                     update_parameters,
  output logic                     busy,
  output logic [IW-1:0]            owner,
  output logic                     done
`ifdef PWM_RAMP_SCHED_ABORT_EN
  , input logic                    abort
`endif
);
  state_t state, nxt_state;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] tgt, step, nxt_duty;
  logic upd_r, done_r, stp, ab, grant_en;
`ifdef PWM_RAMP_SCHED_ABORT_EN
  assign ab = abort && state != IDLE;
`else
  assign ab = 1'b0;
`endif
  assign grant_en = state == IDLE && |req_valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk), .reset(reset), .req(req_valid), .advance(grant_en), .grant(grant), .idx(idx)
  );
  // Gated by reset so req_ready is 0 while reset is held, even with requests pending.
  assign req_ready = reset && state == IDLE ? grant : '0;
  // A period_start seen in the done cycle is ignored: the ramp is already finishing.
  assign stp = state == RAMP && period_start && !done_r && !ab;
  assign nxt_duty = WIDTH'(step_toward(32'(pwm_duty_cycle), 32'(tgt), 32'(step)));
  always_comb begin
    nxt_state = state == IDLE ? (|req_valid ? LOAD : IDLE)
              : state == LOAD ? (ab || tgt == pwm_duty_cycle ? IDLE : RAMP)
              : (ab || done_r ? IDLE : RAMP);
    update_parameters = state == LOAD || upd_r;
    done = !ab && ((state == LOAD && tgt == pwm_duty_cycle) || done_r);
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      tgt <= '0;
      step <= '0;
      pwm_period <= '0;
      pwm_duty_cycle <= '0;
      owner <= '0;
      upd_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state <= nxt_state;
      upd_r <= stp;
      done_r <= stp && nxt_duty == tgt;
      if (stp) pwm_duty_cycle <= nxt_duty;
      if (grant_en) begin
        tgt <= WIDTH'(clamp(32'(req_duty[idx*WIDTH +: WIDTH]), 32'(cfg_period)));
        step <= req_step[idx*WIDTH +: WIDTH];
        pwm_period <= cfg_period;
        owner <= idx;
      end
    end
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// tb_pwm_ramp_scheduler: directed scenarios plus random traffic checked every cycle against a behavioural model.
module tb_pwm_ramp_scheduler;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 0;
  logic reset = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_duty = '0;
  logic [N*W-1:0] req_step = '0;
  logic [W-1:0] cfg_period = 8'd63;
  logic period_start = 0;
  logic [W-1:0] pwm_period, pwm_duty_cycle;
  logic update_parameters, busy, done;
  logic [1:0] owner;
  logic abv;
`ifdef PWM_RAMP_SCHED_ABORT_EN
  logic abort = 0;
  assign abv = abort;
`else
  assign abv = 1'b0;
`endif
  pwm_ramp_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_duty(req_duty), .req_step(req_step), .cfg_period(cfg_period),
    .period_start(period_start), .pwm_period(pwm_period), .pwm_duty_cycle(pwm_duty_cycle),
    .update_parameters(update_parameters), .busy(busy), .owner(owner), .done(done)
`ifdef PWM_RAMP_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int upd_q[$], done_q[$], grant_q[$], ex[$];
  int ps_cnt = 0;
  bit rand_ps = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_q(string nm, input int q[$], input int e[$]);
    chk({nm, "_len"}, q.size(), e.size());
    foreach (e[i]) if (i < q.size()) chk(nm, q[i], e[i]);
  endtask
  function automatic int first_valid(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // Behavioural model: phase 0 idle, 1 load, 2 ramping; m_upd/m_done mark the cycle after a step.
  int m_phase = 0, m_cur = 0, m_tgt = 0, m_step = 0, m_per = 0, m_ptr = 0, m_owner = 0;
  int m_g, m_d, m_s, m_dv;
  bit m_upd = 0, m_done = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_cur = 0; m_tgt = 0; m_step = 0; m_per = 0;
      m_ptr = 0; m_owner = 0; m_upd = 0; m_done = 0;
    end else if (m_phase == 0) begin
      m_upd = 0; m_done = 0;
      m_g = first_valid(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_dv = int'(req_duty[m_g*W +: W]);
        m_tgt = m_dv > int'(cfg_period) ? int'(cfg_period) : m_dv;
        m_step = int'(req_step[m_g*W +: W]);
        m_per = int'(cfg_period);
        m_ptr = (m_g + 1) % N;
        m_owner = m_g;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_upd = 0; m_done = 0;
      m_phase = (abv || m_tgt == m_cur) ? 0 : 2;
    end else begin
      if (abv || m_done) begin
        m_phase = 0; m_upd = 0; m_done = 0;
      end else if (period_start) begin
        m_d = m_tgt > m_cur ? m_tgt - m_cur : m_cur - m_tgt;
        m_s = (m_step == 0 || m_step > m_d) ? m_d : m_step;
        m_cur = m_tgt > m_cur ? m_cur + m_s : m_cur - m_s;
        m_upd = 1;
        m_done = m_cur == m_tgt;
      end else begin
        m_upd = 0; m_done = 0;
      end
    end
  end
  logic [N-1:0] e_ready;
  int e_f;
  always @(negedge clk) begin
    e_f = first_valid(req_valid, m_ptr);
    e_ready = (reset && m_phase == 0 && e_f >= 0) ? N'(1) << e_f : '0;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("update_parameters", 32'(update_parameters), 32'(m_phase == 1 || m_upd));
    chk("done", 32'(done), 32'(!abv && ((m_phase == 1 && m_tgt == m_cur) || m_done)));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("pwm_duty_cycle", 32'(pwm_duty_cycle), m_cur);
    chk("pwm_period", 32'(pwm_period), m_per);
    chk("owner", 32'(owner), m_owner);
    if (update_parameters) upd_q.push_back(int'(pwm_duty_cycle));
    if (done) done_q.push_back(int'(pwm_duty_cycle));
    for (int k = 0; k < N; k++) if (req_ready[k]) grant_q.push_back(k);
  end
  // One cycle: requesters drop valid after their accept pulse; period_start from counter or random.
  task automatic tick();
    logic [N-1:0] rd;
    @(negedge clk);
    rd = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rd;
    if (rand_ps) period_start = $urandom_range(0, 5) == 0;
    else begin
      period_start = ps_cnt == 0;
      ps_cnt = (ps_cnt + 1) % 12;
    end
  endtask
  task automatic set_req(int r, int d, int s);
    req_duty[r*W +: W] = W'(d);
    req_step[r*W +: W] = W'(s);
    req_valid[r] = 1'b1;
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    do begin tick(); n++; end while ((busy || req_valid != 0) && n < lim);
    chk("idle_within_budget", 32'(busy || req_valid != 0), 0);
  endtask
  task automatic wait_upd(int cnt, int lim);
    int n = 0;
    while (upd_q.size() < cnt && n < lim) begin tick(); n++; end
    chk("update_within_budget", 32'(upd_q.size() >= cnt), 1);
  endtask
  task automatic pulse_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask
  task automatic clear_q();
    upd_q.delete(); done_q.delete(); grant_q.delete();
  endtask
  initial begin
    req_valid = '1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_duty", 32'(pwm_duty_cycle), 0);
    chk("rst_period", 32'(pwm_period), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_update", 32'(update_parameters), 0);
    req_valid = '0;
    reset = 1;
    // 1: ramp up 0 -> 10 in steps of 4
    clear_q();
    set_req(0, 10, 4);
    wait_idle(500);
    ex = '{0, 4, 8, 10}; chk_q("t1_updates", upd_q, ex);
    ex = '{10}; chk_q("t1_done", done_q, ex);
    chk("t1_owner", 32'(owner), 0);
    chk("t1_period", 32'(pwm_period), 63);
    // 2: ramp down 10 -> 2 in steps of 3
    clear_q();
    set_req(1, 2, 3);
    wait_idle(500);
    ex = '{10, 7, 4, 2}; chk_q("t2_updates", upd_q, ex);
    ex = '{2}; chk_q("t2_done", done_q, ex);
    tick();
    chk("t2_busy_after", 32'(busy), 0);
    // 4: target clamped to period, step 0 jumps
    clear_q();
    set_req(2, 100, 0);
    wait_idle(500);
    ex = '{2, 63}; chk_q("t4_updates", upd_q, ex);
    ex = '{63}; chk_q("t4_done", done_q, ex);
    // 3: req0 first, then req1..3 together are served in order
    pulse_reset();
    set_req(0, 0, 0);
    wait_idle(100);
    clear_q();
    set_req(1, 5, 0); set_req(2, 6, 0); set_req(3, 7, 0);
    wait_idle(2000);
    ex = '{1, 2, 3}; chk_q("t3_grants", grant_q, ex);
    ex = '{0, 5, 5, 6, 6, 7}; chk_q("t3_updates", upd_q, ex);
    ex = '{5, 6, 7}; chk_q("t3_done", done_q, ex);
    chk("t3_owner", 32'(owner), 3);
    // 5: asynchronous reset mid-ramp, then arbitration restarts at req0
    pulse_reset();
    clear_q();
    set_req(0, 10, 4);
    wait_upd(3, 200);
    tick(); tick();
    set_req(0, 9, 0); set_req(2, 30, 0);
    #2 reset = 0;
    #1;
    chk("t5_duty", 32'(pwm_duty_cycle), 0);
    chk("t5_period", 32'(pwm_period), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_owner", 32'(owner), 0);
    @(posedge clk); #1 reset = 1;
    clear_q();
    wait_idle(2000);
    ex = '{0, 2}; chk_q("t5_grants", grant_q, ex);
`ifdef PWM_RAMP_SCHED_ABORT_EN
    // 6: abort at duty 8 of target 20
    pulse_reset();
    clear_q();
    set_req(0, 20, 4);
    wait_upd(3, 200);
    abort = 1;
    tick();
    abort = 0;
    tick(); tick();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_duty", 32'(pwm_duty_cycle), 8);
    repeat (30) tick();
    chk("t6_updates", upd_q.size(), 3);
    chk("t6_done", done_q.size(), 0);
`endif
    // Random traffic with random period_start, drops before grant
    rand_ps = 1;
    cfg_period = 8'd200;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r = $urandom_range(0, N - 1);
        if (!req_valid[r]) set_req(r, $urandom_range(0, 255), $urandom_range(0, 20));
      end
      if ($urandom_range(0, 15) == 0) req_valid[$urandom_range(0, N - 1)] = 1'b0;
      tick();
    end
    rand_ps = 0;
    req_valid = '0;
    wait_idle(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
